// File: rtl/key_bounce_gen_pkg.sv
// Shared key-handling constants: FSM states, LFSR geometry and seed.
// Imported by the key bounce generator and its LFSR.
package key_bounce_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_BOUNCE,
        ST_HOLD,
        ST_REL_BOUNCE
    } key_state_e;

    localparam int PHASE_W = 24;
    localparam int GAP_W   = 8;
    localparam int LFSR_W  = 16;

    // x^16+x^14+x^13+x^11+1, right-shifting form: taps at bits 0,2,3,5
    localparam logic [LFSR_W-1:0] LFSR_TAPS     = 16'h002D;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 16'hACE1;

    function automatic logic [LFSR_W-1:0] lfsr_step(
        input logic [LFSR_W-1:0] s
    );
        return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/key_bounce_gen_lfsr16.sv
// 16-bit Fibonacci LFSR, free-running from reset.
// A nonzero seed keeps it off the all-zero lock-up state.
module lfsr16
    import key_bounce_gen_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= SEED;
        end else begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/key_bounce_gen.sv
// Mechanical key emulator: bouncy press, stable hold, bouncy release.
// One press_req in IDLE runs one full sequence ending in a done pulse.
module key_bounce_gen
    import key_bounce_gen_pkg::*;
#(
    parameter logic [PHASE_W-1:0] BOUNCE_TIME_CNT = 24'd200_000,
    parameter logic [PHASE_W-1:0] HOLD_TIME_CNT   = 24'd5_000_000,
    parameter logic [LFSR_W-1:0]  LFSR_SEED       = LFSR_SEED_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic press_req,
    output logic key_sim,
    output logic busy,
    output logic done
);

    localparam logic [PHASE_W-1:0] BOUNCE_LAST = BOUNCE_TIME_CNT - PHASE_W'(1);
    localparam logic [PHASE_W-1:0] HOLD_LAST   = HOLD_TIME_CNT - PHASE_W'(1);

    key_state_e         state_q;
    key_state_e         state_d;
    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gap_d;
    logic [GAP_W-1:0]   gap_next;
    logic               gap_hit;
    logic               key_d;
    logic               busy_d;
    logic               done_d;

    logic [LFSR_W-1:0]       lfsr;
    logic [GAP_W-1:0]        lfsr_lo;
    logic [LFSR_W-GAP_W-1:0] lfsr_unused;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .state     (lfsr)
    );

    assign {lfsr_unused, lfsr_lo} = lfsr;

    // A loaded gap of g toggles g+1 cycles later: spacing 1..256
    assign gap_hit  = (gap_q == '0);
    assign gap_next = gap_hit ? lfsr_lo : gap_q - GAP_W'(1);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q + PHASE_W'(1);
        gap_d   = gap_q;
        key_d   = key_sim;
        busy_d  = busy;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                key_d   = 1'b1;
                busy_d  = 1'b0;
                if (press_req && !done) begin
                    state_d = ST_PRESS_BOUNCE;
                    key_d   = 1'b0;
                    busy_d  = 1'b1;
                    gap_d   = lfsr_lo;
                end
            end
            ST_PRESS_BOUNCE: begin
                gap_d = gap_next;
                key_d = key_sim ^ gap_hit;
                if (phase_q == BOUNCE_LAST) begin
                    state_d = ST_HOLD;
                    phase_d = '0;
                    key_d   = 1'b0;
                end
            end
            ST_HOLD: begin
                key_d = 1'b0;
                if (phase_q == HOLD_LAST) begin
                    state_d = ST_REL_BOUNCE;
                    phase_d = '0;
                    key_d   = 1'b1;
                    gap_d   = lfsr_lo;
                end
            end
            ST_REL_BOUNCE: begin
                gap_d = gap_next;
                key_d = key_sim ^ gap_hit;
                if (phase_q == BOUNCE_LAST) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                    key_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            gap_q   <= '0;
            key_sim <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            gap_q   <= gap_d;
            key_sim <= key_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_key_bounce_gen.sv
// Randomized self-checking bench for key_bounce_gen using a
// toggle-schedule reference model driven by a reference LFSR.
module tb_key_bounce_gen;

    localparam int BT  = 100;
    localparam int HT  = 1000;
    localparam int SEQ = 2 * BT + HT;
    localparam logic [15:0] SEED = 16'hACE1;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    logic press_req;
    logic key_sim;
    logic busy;
    logic done;

    int checks   = 0;
    int failures = 0;

    int          cyc;
    logic [15:0] lm;
    logic [15:0] lhist [0:65535];

    key_bounce_gen #(
        .BOUNCE_TIME_CNT (24'd100),
        .HOLD_TIME_CNT   (24'd1000),
        .LFSR_SEED       (16'hACE1)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .press_req (press_req),
        .key_sim   (key_sim),
        .busy      (busy),
        .done      (done)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    // lhist[k]: LFSR value after k edges since reset release
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cyc = 0;
            lm  = SEED;
            lhist[0] = SEED;
        end else begin
            cyc = cyc + 1;
            lm  = lfsr_ref(lm);
            lhist[cyc[15:0]] = lm;
        end
    end

    // Cycles from a gap load at edge e to the toggle it schedules
    function automatic int spacing_at(input int e);
        logic [15:0] v;
        v = lhist[(e - 1) & 16'hFFFF];
        return int'(v[7:0]) + 1;
    endfunction

    // Caller has pressed so edge a accepted; now just after edge a
    task automatic track(input int a, input bit rereq,
                         output int tg_press);
        int   d;
        int   r;
        int   nt;
        int   last_t;
        int   key_err;
        int   busy_err;
        int   done_err;
        int   done_cnt;
        int   sp_err;
        int   lz_err;
        int   first_e;
        logic kexp;
        logic kobs;
        logic prev;
        logic bexp;
        logic dexp;
        d = a + SEQ;
        r = a + BT + HT;
        key_err = 0; busy_err = 0; done_err = 0; done_cnt = 0;
        sp_err = 0; lz_err = 0; first_e = -1;
        kexp = 1'b0; kobs = 1'b0; prev = 1'b0;
        nt = a + spacing_at(a);
        last_t = a;
        tg_press = 0;
        for (int e = a; e <= d; e++) begin
            if (e > a) begin
                @(negedge sys_clk);
                if (e < a + BT) begin
                    if (e == nt) begin
                        kexp = ~kexp;
                        nt = e + spacing_at(e);
                    end
                end else if (e < r) begin
                    kexp = 1'b0;
                end else if (e == r) begin
                    kexp = 1'b1;
                    nt = r + spacing_at(r);
                end else if (e < d) begin
                    if (e == nt) begin
                        kexp = ~kexp;
                        nt = e + spacing_at(e);
                    end
                end else begin
                    kexp = 1'b1;
                end
            end
            bexp = (e < d);
            dexp = (e == d);
            if (key_sim !== kexp) begin
                key_err++;
                if (first_e < 0) begin
                    first_e = e - a;
                    kobs = key_sim;
                end
            end
            if (busy !== bexp) busy_err++;
            if (done !== dexp) done_err++;
            if (done === 1'b1) done_cnt++;
            if (e > a && key_sim !== prev &&
                (e < a + BT || (e > r && e < d))) begin
                if (e - last_t > 256) sp_err++;
                if (e < a + BT) tg_press++;
                last_t = e;
            end
            if (e == r) last_t = r;
            prev = key_sim;
            if (dut.lfsr === 16'h0000) lz_err++;
            press_req = rereq &&
                (e - a == 49 || e - a == 599 || e - a == 1149);
        end
        checks++;
        if (key_err != 0)
            $display("FAIL key_sim_wave: %0d bad cycles, first at +%0d got %b want %b",
                     key_err, first_e, kobs, ~kobs);
        if (key_err != 0) failures++;
        checks++;
        if (busy_err != 0) begin
            $display("FAIL busy_wave: %0d bad cycles, want 0", busy_err);
            failures++;
        end
        checks++;
        if (done_err != 0 || done_cnt != 1) begin
            $display("FAIL done_pulse: %0d pulses, %0d bad cycles, want 1 at +%0d",
                     done_cnt, done_err, SEQ);
            failures++;
        end
        checks++;
        if (sp_err != 0) begin
            $display("FAIL toggle_spacing: %0d intervals over 256", sp_err);
            failures++;
        end
        checks++;
        if (lz_err != 0) begin
            $display("FAIL lfsr_nonzero: zero seen %0d times, want 0", lz_err);
            failures++;
        end
    endtask

    task automatic press_now(output int a);
        press_req = 1'b1;
        a = cyc + 1;
        @(negedge sys_clk);
        press_req = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        press_req = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (key_sim !== 1'b1) begin
            $display("FAIL reset_key: got %b want 1", key_sim);
            failures++;
        end
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL reset_busy: got %b want 0", busy);
            failures++;
        end
        checks++;
        if (done !== 1'b0) begin
            $display("FAIL reset_done: got %b want 0", done);
            failures++;
        end
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_single_press();
        int a;
        int tg;
        int n;
        logic [15:0] v;
        n = 0;
        v = lhist[cyc[15:0]];
        while (v[7:0] >= 8'd90 && n < 3000) begin
            @(negedge sys_clk);
            v = lhist[cyc[15:0]];
            n++;
        end
        checks++;
        if (n >= 3000) begin
            $display("FAIL short_gap_wait: no small gap in %0d cycles", n);
            failures++;
        end
        press_now(a);
        track(a, 1'b0, tg);
        checks++;
        if (tg < 1) begin
            $display("FAIL press_toggle: got %0d toggles want >=1", tg);
            failures++;
        end
        @(negedge sys_clk);
        checks++;
        if (done !== 1'b0 || key_sim !== 1'b1) begin
            $display("FAIL post_done: done=%b key=%b want 0/1", done, key_sim);
            failures++;
        end
    endtask

    task automatic test_repeat_req();
        int a;
        int tg;
        repeat (1 + $urandom_range(0, 5)) @(negedge sys_clk);
        press_now(a);
        track(a, 1'b1, tg);
        @(negedge sys_clk);
    endtask

    task automatic test_back_to_back();
        int a;
        int tg;
        repeat (2) @(negedge sys_clk);
        press_now(a);
        track(a, 1'b0, tg);
        press_req = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (busy !== 1'b0 || key_sim !== 1'b1) begin
            $display("FAIL req_on_done: busy=%b key=%b want 0/1", busy, key_sim);
            failures++;
        end
        press_now(a);
        track(a, 1'b0, tg);
        @(negedge sys_clk);
    endtask

    task automatic test_mid_reset();
        int a;
        int tg;
        int dseen;
        press_now(a);
        repeat (499) @(negedge sys_clk);
        checks++;
        if (busy !== 1'b1 || key_sim !== 1'b0) begin
            $display("FAIL mid_hold: busy=%b key=%b want 1/0", busy, key_sim);
            failures++;
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (key_sim !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL async_reset: key=%b busy=%b want 1/0", key_sim, busy);
            failures++;
        end
        dseen = 0;
        repeat (3) begin
            @(negedge sys_clk);
            if (done !== 1'b0) dseen++;
        end
        checks++;
        if (dseen != 0) begin
            $display("FAIL abort_done: got %0d done cycles want 0", dseen);
            failures++;
        end
        sys_rst_n = 1'b1;
        press_now(a);
        checks++;
        if (a != 1) begin
            $display("FAIL first_edge_accept: got edge %0d want 1", a);
            failures++;
        end
        track(a, 1'b0, tg);
        @(negedge sys_clk);
    endtask

    task automatic test_toggle_spacing();
        int a;
        int tg;
        for (int i = 0; i < 20; i++) begin
            repeat (1 + $urandom_range(0, 7)) @(negedge sys_clk);
            press_now(a);
            track(a, 1'b0, tg);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_press();
        test_repeat_req();
        test_back_to_back();
        test_mid_reset();
        test_toggle_spacing();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
